uio_bus_arbiter: RTL
====================

Name: uio_bus_arbiter

Overview:
- Shares the 8-bit bidirectional uio pin bank among NREQ internal requesters inside ChiselTop.
- Round-robin grant with a bounded hold time and a forced turnaround gap between owners, so two drivers never collide on the pads.
- Sits between the requester logic and the io_uio_in / io_uio_out / io_uio_oe top-level signals.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, uio bus width.
- MAX_HOLD, 16, max consecutive GRANT cycles while another request is pending (>=1).
- TURN, 1, idle turnaround cycles after each release (>=1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- io_req  in  NREQ  per-requester request; held high to keep the bus.
- io_dir  in  NREQ  per-requester direction; 1=drive pins, 0=read pins.
- io_wdata  in  NREQ*WIDTH  write data; slice i belongs to requester i.
- io_gnt  out  NREQ  one-hot grant, registered.
- io_rdata  out  WIDTH  registered sample of uio pins.
- io_busy  out  1  high when the state is not IDLE.
- io_uio_in  in  WIDTH  pad input.
- io_uio_out  out  WIDTH  pad output.
- io_uio_oe  out  WIDTH  pad output enable.

Behaviour:
- Reset (async, immediate):
  - State=IDLE; gnt=0, uio_out=0, uio_oe=0, rdata=0, busy=0.
  - hold_cnt=0, last=NREQ-1, so requester 0 wins first.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req!=0, winner = first set bit searching circularly from last+1.
  - Next cycle: state=GRANT, gnt=onehot(winner), last=winner, dir_lat=io_dir[winner], hold_cnt=0.
  - Request-to-grant latency is exactly 1 cycle.
- GRANT (owner w):
  - uio_oe = dir_lat ? all ones : 0.
  - uio_out = dir_lat ? io_wdata slice w : 0, combinational from gnt register and wdata.
  - Direction is latched at grant; io_dir changes during the grant are ignored.
  - hold_cnt increments each cycle and saturates at MAX_HOLD-1.
  - Release when req[w]=0, or when hold_cnt==MAX_HOLD-1 and any other req is set.
  - On release, the next cycle enters TURN.
  - A lone requester holding req keeps the bus indefinitely.
- TURN:
  - gnt=0, uio_oe=0, uio_out=0 for exactly TURN cycles, counted by a separate counter.
  - Then arbitrate as in IDLE in the same cycle the count expires: GRANT if req!=0, else IDLE.
- rdata:
  - In GRANT with dir_lat=0, rdata <= io_uio_in every cycle.
  - Otherwise rdata holds its value.
  - First valid sample appears 1 cycle after the first GRANT cycle.
- Simultaneous events:
  - The owner dropping req and another requester raising req in the same cycle still passes through TURN.
  - Requests arriving during TURN are arbitrated at TURN expiry.
- Invariants:
  - gnt is zero or one-hot.
  - uio_oe is nonzero only in GRANT.
  - There is never a cycle where the owner changes without at least TURN idle cycles in between.

Optional Feature:
- Macro: UIO_ARB_PRIO_EN.
- Defined:
  - Requester 0 is high priority. At every arbitration point, if req[0]=1 it wins regardless of round-robin.
  - In GRANT with owner w!=0, req[0]=1 forces release at the end of the current cycle (preemption), then TURN, then grant 0.
  - last is not updated by priority grants.
- Undefined: pure round-robin as above; no preemption logic is synthesized.

Test Plan:
- Reset then req=0001, dir=1, wdata0=0xA5 -> gnt=0001 at cycle 1; uio_oe=0xFF, uio_out=0xA5; busy=1.
- req=0011 held, MAX_HOLD=16 -> gnt0 for 16 cycles, 1 TURN cycle with oe=0, then gnt=0010 for 16 cycles, then TURN, then gnt0 again.
- Owner 1 with dir=0, uio_in=0x3C -> uio_oe=0x00; rdata=0x3C one cycle after the first GRANT cycle; rdata holds after release.
- Owner 2 driving, reset asserted mid-grant (not aligned to a clock edge) -> gnt, uio_oe and uio_out go to 0 immediately; after reset release with req=0100, gnt=0100 after 1 cycle.
- Owner drops req while req3 rises in the same cycle -> exactly TURN=1 idle cycle, then gnt=1000; dir toggled during the grant does not change oe.
- UIO_ARB_PRIO_EN defined, owner 2 active, req0 rises -> gnt2 cleared next cycle, 1 TURN cycle, then gnt=0001. Undefined: owner 2 keeps the bus until MAX_HOLD expires.

Source files
------------

// File: rtl/uio_bus_arbiter.sv
// rtl/uio_bus_arbiter.sv - round-robin owner arbitration of the shared uio pad bank with turnaround gaps
// Optional UIO_ARB_PRIO_EN: requester 0 wins every arbitration and preempts other owners.
module uio_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16,
  parameter int TURN     = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         io_req,
  input  logic [NREQ-1:0]         io_dir,
  input  logic [NREQ*WIDTH-1:0]   io_wdata,
  output logic [NREQ-1:0]         io_gnt,
  output logic [WIDTH-1:0]        io_rdata,
  output logic                    io_busy,
  input  logic [WIDTH-1:0]        io_uio_in,
  output logic [WIDTH-1:0]        io_uio_out,
  output logic [WIDTH-1:0]        io_uio_oe
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN - 1);
  localparam logic [IW-1:0] LAST_RST  = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE     = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

  state_t           r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [IW-1:0]    r_last;
  logic             r_dir_lat;
  logic [HW-1:0]    r_hold_cnt;
  logic [TW-1:0]    r_turn_cnt;
  logic [WIDTH-1:0] r_rdata;

  logic [IW-1:0]    w_idx;
  logic [IW-1:0]    w_winner;
  logic             w_any;
  logic             w_arb_now;
  logic             w_release;
  logic [WIDTH-1:0] w_sel;
`ifdef UIO_ARB_PRIO_EN
  logic             w_prio;
`endif

  // Circular search from last+1; iterating downward leaves the nearest requester in w_winner.
  always_comb begin
    w_any    = |io_req;
    w_winner = '0;
    w_idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IW'((int'(r_last) + k) % NREQ);
      if (io_req[w_idx]) w_winner = w_idx;
    end
`ifdef UIO_ARB_PRIO_EN
    w_prio = io_req[0];
    if (io_req[0]) w_winner = '0;
`endif
  end

  always_comb begin
    w_release = !(|(io_req & r_gnt)) ||
                ((r_hold_cnt == HOLD_LAST) && (|(io_req & ~r_gnt)));
`ifdef UIO_ARB_PRIO_EN
    w_release = w_release || (io_req[0] && !r_gnt[0]);
`endif
  end

  assign w_arb_now = (r_state == S_IDLE) ||
                     ((r_state == S_TURN) && (r_turn_cnt == TURN_LAST));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_last     <= LAST_RST;
      r_dir_lat  <= 1'b0;
      r_hold_cnt <= '0;
      r_turn_cnt <= '0;
      r_rdata    <= '0;
    end else if (r_state == S_GRANT) begin
      if (!r_dir_lat) r_rdata <= io_uio_in;
      if (w_release) begin
        r_state    <= S_TURN;
        r_gnt      <= '0;
        r_dir_lat  <= 1'b0;
        r_turn_cnt <= '0;
      end else if (r_hold_cnt != HOLD_LAST) begin
        r_hold_cnt <= r_hold_cnt + HW'(1);
      end
    end else if (w_arb_now) begin
      if (w_any) begin
        r_state    <= S_GRANT;
        r_gnt      <= ONE << w_winner;
        r_dir_lat  <= io_dir[w_winner];
        r_hold_cnt <= '0;
`ifdef UIO_ARB_PRIO_EN
        if (!w_prio) r_last <= w_winner;
`else
        r_last     <= w_winner;
`endif
      end else begin
        r_state <= S_IDLE;
      end
    end else begin
      r_turn_cnt <= r_turn_cnt + TW'(1);
    end
  end

  // Pad data follows the grant register directly so it is valid in the first owned cycle.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt[i]) w_sel = w_sel | io_wdata[i*WIDTH +: WIDTH];
    end
  end

  assign io_uio_out = r_dir_lat ? w_sel : '0;
  assign io_uio_oe  = (r_dir_lat && (|r_gnt)) ? '1 : '0;
  assign io_gnt     = r_gnt;
  assign io_rdata   = r_rdata;
  assign io_busy    = (r_state != S_IDLE);

endmodule
